// File: rtl/mem_fill_sched.sv
// Memory scheduler for the I-cache and D-cache. It arbitrates their requests, streams
// block fills as back-to-back reads, and returns each word with its address.
module mem_fill_sched #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_irequest,
    input  logic [15:0] i_iaddr,
    input  logic        i_drequest,
    input  logic [15:0] i_daddr,
    input  logic        i_dwrite,
    input  logic [15:0] i_dwdata,
    output logic        o_iservice,
    output logic        o_dservice,
    output logic        o_data_valid,
    output logic [15:0] o_data_out,
    output logic [15:0] o_fill_addr,
    output logic        o_mem_enable,
    output logic        o_mem_wr,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata
);

    localparam int CNT_W = $clog2(WORDS_PER_BLOCK) + 1;
    // The byte offset inside a block covers the word index plus the byte-in-word bit.
    localparam logic [15:0] BASE_MASK = ~16'((1 << ($clog2(WORDS_PER_BLOCK) + 1)) - 1);

    typedef enum logic [1:0] {S_IDLE, S_IFILL, S_DFILL, S_DWRITE} state_t;

    state_t                 r_state, w_next;
    logic [15:0]            r_base;
    logic [CNT_W-1:0]       r_issue_cnt;
    logic [CNT_W-1:0]       r_ret_cnt;
    logic [MEM_LATENCY-1:0] r_vld_pipe;

    logic        w_fill, w_issue, w_last, w_grant;
    logic [15:0] w_req_addr, w_iss_addr, w_ret_addr;

    assign w_fill     = (r_state == S_IFILL) || (r_state == S_DFILL);
    assign w_issue    = w_fill && (r_issue_cnt < CNT_W'(WORDS_PER_BLOCK));
    assign w_last     = r_vld_pipe[MEM_LATENCY-1] && (r_ret_cnt == CNT_W'(WORDS_PER_BLOCK - 1));
    assign w_grant    = i_drequest || i_irequest;
    assign w_req_addr = i_drequest ? i_daddr : i_iaddr;
    assign w_iss_addr = r_base + (16'(r_issue_cnt) << 1);
    assign w_ret_addr = r_base + (16'(r_ret_cnt) << 1);

    assign o_data_valid = r_vld_pipe[MEM_LATENCY-1];
    assign o_data_out   = i_mem_rdata;
    assign o_fill_addr  = o_data_valid ? w_ret_addr : 16'h0000;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_vld_pipe  <= '0;
        end else begin
            r_state <= w_next;
            // Tracks outstanding reads; each slot is one cycle of memory latency.
            r_vld_pipe[0] <= w_issue;
            for (int k = 1; k < MEM_LATENCY; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
            end
            if (r_state == S_IDLE) begin
                r_issue_cnt <= '0;
                r_ret_cnt   <= '0;
                if (w_grant) begin
                    r_base <= w_req_addr & BASE_MASK;
                end
            end else begin
                if (w_issue) begin
                    r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                end
                if (o_data_valid) begin
                    r_ret_cnt <= r_ret_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        o_iservice   = 1'b0;
        o_dservice   = 1'b0;
        o_mem_enable = 1'b0;
        o_mem_wr     = 1'b0;
        o_mem_addr   = 16'h0000;
        o_mem_wdata  = 16'h0000;
        case (r_state)
            S_IDLE: begin
                // The data side wins: a stalled load/store holds the whole pipeline.
                if (i_drequest) begin
                    w_next = i_dwrite ? S_DWRITE : S_DFILL;
                end else if (i_irequest) begin
                    w_next = S_IFILL;
                end
            end
            S_IFILL, S_DFILL: begin
                o_iservice   = (r_state == S_IFILL);
                o_dservice   = (r_state == S_DFILL);
                o_mem_enable = w_issue;
                o_mem_addr   = w_issue ? w_iss_addr : 16'h0000;
                if (w_last) begin
                    w_next = S_IDLE;
                end
            end
            S_DWRITE: begin
                o_dservice   = 1'b1;
                o_mem_enable = 1'b1;
                o_mem_wr     = 1'b1;
                o_mem_addr   = i_daddr;
                o_mem_wdata  = i_dwdata;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
